// File: rtl/ysyx_25030081_exec_seq.sv
// Multi-cycle IF/EX/MEM/WB sequencer owning the core's single memory bus port.
// 3 cycles per ALU op, 6 per load/store on a zero-wait bus; stalls while request or response is not handshaked.
module ysyx_25030081_exec_seq #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   output logic [31:0]       inst,
   input  logic              dec_reg_wen,
   input  logic              dec_mem_ren,
   input  logic              dec_mem_wen,
   input  logic [2:0]        dec_mem_op,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [31:0]       lsu_wdata,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic [ADDR_W-1:0] bus_req_addr,
   output logic              bus_req_wen,
   output logic [31:0]       bus_req_wdata,
   output logic [3:0]        bus_req_wmask,
   input  logic              bus_resp_valid,
   output logic              bus_resp_ready,
   input  logic [31:0]       bus_resp_rdata,
   input  logic              bus_resp_err,
   output logic              pc_wen,
   output logic              rf_wen,
   output logic [31:0]       load_data,
   output logic              commit,
   output logic              halt
);

   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("RESET_PC must be word aligned");
   end

   typedef enum logic [2:0] {
      S_IF_REQ, S_IF_WAIT, S_EX, S_MEM_REQ, S_MEM_WAIT, S_WB, S_ERR
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] load_data_q, load_data_d;

   logic              req_vld, resp_rdy, req_wen, pc_we, rf_we, cmt;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wmask;

   logic        is_mem, is_word, is_half, misaligned;
   logic [1:0]  mem_off;
   logic [31:0] st_wdata, rd_shift, ld_ext;
   logic [3:0]  st_wmask;
   logic        pc_lo_unused;

   assign pc_lo_unused = ^pc[1:0];

   assign is_mem     = dec_mem_ren | dec_mem_wen;
   assign mem_off    = lsu_addr[1:0];
   assign is_word    = dec_mem_op[1];
   assign is_half    = ~dec_mem_op[1] & dec_mem_op[0];
   assign misaligned = (is_word && mem_off != 2'b00) || (is_half && mem_off[0]);

   // Store lanes: data replicated to every lane, strobes pick the addressed bytes.
   always_comb begin
      st_wdata = {4{lsu_wdata[7:0]}};
      st_wmask = 4'b0001 << mem_off;
      if (is_word) begin
         st_wdata = lsu_wdata;
         st_wmask = 4'hF;
      end else if (is_half) begin
         st_wdata = {2{lsu_wdata[15:0]}};
         st_wmask = 4'b0011 << mem_off;
      end
   end

   // Halves are guaranteed even-aligned here, so one byte-granular shift serves both sizes.
   assign rd_shift = bus_resp_rdata >> {mem_off, 3'b000};

   always_comb begin
      ld_ext = dec_mem_op[2] ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      if (is_word) begin
         ld_ext = bus_resp_rdata;
      end else if (is_half) begin
         ld_ext = dec_mem_op[2] ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
   end

   always_comb begin
      state_d     = state_q;
      inst_d      = inst_q;
      load_data_d = load_data_q;
      req_vld     = 1'b0;
      resp_rdy    = 1'b0;
      req_wen     = 1'b0;
      req_addr    = '0;
      req_wdata   = 32'h0;
      req_wmask   = 4'h0;
      pc_we       = 1'b0;
      rf_we       = 1'b0;
      cmt         = 1'b0;
      case (state_q)
         S_IF_REQ: begin
            req_vld  = 1'b1;
            req_addr = {pc[ADDR_W-1:2], 2'b00};
            if (bus_req_ready) state_d = S_IF_WAIT;
         end
         S_IF_WAIT: begin
            resp_rdy = 1'b1;
            if (bus_resp_valid) begin
               if (bus_resp_err) begin
                  state_d = S_ERR;
               end else begin
                  inst_d  = bus_resp_rdata;
                  state_d = S_EX;
               end
            end
         end
         S_EX: begin
            if (is_mem) begin
               state_d = misaligned ? S_ERR : S_MEM_REQ;
            end else begin
               pc_we   = 1'b1;
               rf_we   = dec_reg_wen;
               cmt     = 1'b1;
               state_d = S_IF_REQ;
            end
         end
         S_MEM_REQ: begin
            req_vld  = 1'b1;
            req_addr = {lsu_addr[ADDR_W-1:2], 2'b00};
            req_wen  = dec_mem_wen;
            if (dec_mem_wen) begin
               req_wdata = st_wdata;
               req_wmask = st_wmask;
            end
            if (bus_req_ready) state_d = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            resp_rdy = 1'b1;
            if (bus_resp_valid) begin
               if (bus_resp_err) begin
                  state_d = S_ERR;
               end else begin
                  if (dec_mem_ren) load_data_d = ld_ext;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            pc_we   = 1'b1;
            rf_we   = dec_reg_wen;
            cmt     = 1'b1;
            state_d = S_IF_REQ;
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IF_REQ;
         inst_q      <= 32'h0000_0013;
         load_data_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         inst_q      <= inst_d;
         load_data_q <= load_data_d;
      end
   end

   // State resets to IF_REQ, so handshake and strobes are also gated by rst_n itself.
   assign bus_req_valid  = req_vld & rst_n;
   assign bus_resp_ready = resp_rdy & rst_n;
   assign bus_req_addr   = req_addr;
   assign bus_req_wen    = req_wen;
   assign bus_req_wdata  = req_wdata;
   assign bus_req_wmask  = req_wmask;
   assign pc_wen         = pc_we & rst_n;
   assign rf_wen         = rf_we & rst_n;
   assign commit         = cmt & rst_n;
   assign halt           = (state_q == S_ERR);
   assign inst           = inst_q;
   assign load_data      = load_data_q;

endmodule

// File: tb/tb_ysyx_25030081_exec_seq.sv
// Directed bench: the bench plays PC register, decoder and memory bus for the exec sequencer.
module tb_ysyx_25030081_exec_seq;

   logic        clk, rst_n;
   logic [31:0] pc, inst;
   logic        dec_reg_wen, dec_mem_ren, dec_mem_wen;
   logic [2:0]  dec_mem_op;
   logic [31:0] lsu_addr, lsu_wdata;
   logic        bus_req_valid, bus_req_ready, bus_req_wen;
   logic [31:0] bus_req_addr, bus_req_wdata;
   logic [3:0]  bus_req_wmask;
   logic        bus_resp_valid, bus_resp_ready, bus_resp_err;
   logic [31:0] bus_resp_rdata;
   logic        pc_wen, rf_wen, commit, halt;
   logic [31:0] load_data;

   int n_vec = 0;
   int n_bad = 0;

   ysyx_25030081_exec_seq dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .inst(inst),
      .dec_reg_wen(dec_reg_wen), .dec_mem_ren(dec_mem_ren), .dec_mem_wen(dec_mem_wen),
      .dec_mem_op(dec_mem_op), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
      .bus_req_wen(bus_req_wen), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
      .bus_resp_valid(bus_resp_valid), .bus_resp_ready(bus_resp_ready),
      .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err),
      .pc_wen(pc_wen), .rf_wen(rf_wen), .load_data(load_data), .commit(commit), .halt(halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_dec();
      dec_reg_wen = 1'b0; dec_mem_ren = 1'b0; dec_mem_wen = 1'b0;
      dec_mem_op  = 3'b000; lsu_addr = 32'h0; lsu_wdata = 32'h0;
   endtask

   // Zero-wait fetch; returns positioned in the EX cycle.
   task automatic fetch(input logic [31:0] word);
      bus_req_ready = 1'b1;
      #1;
      chk("if_vld",  bus_req_valid, 32'd1);
      chk("if_addr", bus_req_addr, pc);
      chk("if_wen",  bus_req_wen, 32'd0);
      chk("if_mask", bus_req_wmask, 32'd0);
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = word;
      #1;
      chk("iw_rdy",    bus_resp_ready, 32'd1);
      chk("iw_commit", commit, 32'd0);
      tick();
      bus_resp_valid = 1'b0; bus_resp_rdata = 32'h0;
   endtask

   task automatic mem_op(input logic is_st, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
      fetch(is_st ? 32'h0020_2023 : 32'h0000_2083);
      dec_mem_ren = ~is_st; dec_mem_wen = is_st; dec_reg_wen = ~is_st;
      dec_mem_op = op; lsu_addr = addr; lsu_wdata = wd;
      #1;
      chk("ex_commit", commit, 32'd0);
      chk("ex_vld",    bus_req_valid, 32'd0);
      tick();
      bus_req_ready = 1'b1;
      #1;
      chk("mr_vld",  bus_req_valid, 32'd1);
      chk("mr_addr", bus_req_addr, {addr[31:2], 2'b00});
      chk("mr_wen",  bus_req_wen, {31'd0, is_st});
      chk("mr_mask", bus_req_wmask, {28'd0, exp_mask});
      if (is_st) chk("mr_wdata", bus_req_wdata, exp_wdata);
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_rdata = rdata;
      #1;
      chk("mw_rdy", bus_resp_ready, 32'd1);
      tick();
      bus_resp_valid = 1'b0;
      #1;
      chk("wb_commit", commit, 32'd1);
      chk("wb_pcwen",  pc_wen, 32'd1);
      chk("wb_rfwen",  rf_wen, {31'd0, ~is_st});
      chk("wb_vld",    bus_req_valid, 32'd0);
      if (!is_st) chk("wb_ldata", load_data, exp_ld);
      tick();
      pc = pc + 32'd4;
      clr_dec();
   endtask

   initial begin
      rst_n = 1'b1; pc = 32'h8000_0000;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0; bus_resp_rdata = 32'h0;
      clr_dec();
      #3 rst_n = 1'b0;
      #1;
      chk("rst_vld",   bus_req_valid, 32'd0);
      chk("rst_rrdy",  bus_resp_ready, 32'd0);
      chk("rst_cmt",   commit, 32'd0);
      chk("rst_pcwen", pc_wen, 32'd0);
      chk("rst_halt",  halt, 32'd0);
      chk("rst_inst",  inst, 32'h0000_0013);
      chk("rst_ldata", load_data, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // addi: retires in the third cycle
      fetch(32'h0010_0093);
      dec_reg_wen = 1'b1;
      #1;
      chk("addi_inst",  inst, 32'h0010_0093);
      chk("addi_cmt",   commit, 32'd1);
      chk("addi_pcwen", pc_wen, 32'd1);
      chk("addi_rfwen", rf_wen, 32'd1);
      chk("addi_vld",   bus_req_valid, 32'd0);
      tick();
      pc = pc + 32'd4; clr_dec();

      mem_op(1'b0, 3'b000, 32'h8000_0103, 32'h0, 32'h80AB_CDEF, 4'h0, 32'h0, 32'hFFFF_FF80); // lb
      mem_op(1'b0, 3'b010, 32'h8000_0104, 32'h0, 32'hDEAD_BEEF, 4'h0, 32'h0, 32'hDEAD_BEEF); // lw
      mem_op(1'b0, 3'b001, 32'h8000_0106, 32'h0, 32'h8765_4321, 4'h0, 32'h0, 32'hFFFF_8765); // lh
      mem_op(1'b0, 3'b100, 32'h8000_0105, 32'h0, 32'h80AB_CDEF, 4'h0, 32'h0, 32'h0000_00CD); // lbu
      mem_op(1'b1, 3'b000, 32'h8000_0201, 32'h0000_0055, 32'h0, 4'b0010, 32'h5555_5555, 32'h0); // sb
      mem_op(1'b1, 3'b010, 32'h8000_0204, 32'h1234_5678, 32'h0, 4'b1111, 32'h1234_5678, 32'h0); // sw

      // lhu with the response held off for three cycles
      fetch(32'h0000_5083);
      dec_mem_ren = 1'b1; dec_reg_wen = 1'b1; dec_mem_op = 3'b101; lsu_addr = 32'h8000_0202;
      tick();
      bus_req_ready = 1'b1;
      #1;
      chk("lhu_addr", bus_req_addr, 32'h8000_0200);
      tick();
      bus_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("dly_cmt", commit, 32'd0);
         chk("dly_rdy", bus_resp_ready, 32'd1);
         tick();
      end
      bus_resp_valid = 1'b1; bus_resp_rdata = 32'h8765_4321;
      tick();
      bus_resp_valid = 1'b0;
      #1;
      chk("lhu_cmt",   commit, 32'd1);
      chk("lhu_ldata", load_data, 32'h0000_8765);
      tick();
      pc = pc + 32'd4; clr_dec();

      // sh with request accept held off for five cycles
      fetch(32'h0020_1123);
      dec_mem_wen = 1'b1; dec_mem_op = 3'b001; lsu_addr = 32'h8000_0302; lsu_wdata = 32'h1234_ABCD;
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_vld",  bus_req_valid, 32'd1);
         chk("stall_addr", bus_req_addr, 32'h8000_0300);
         tick();
      end
      bus_req_ready = 1'b1;
      #1;
      chk("sh_wen",   bus_req_wen, 32'd1);
      chk("sh_mask",  bus_req_wmask, 32'hC);
      chk("sh_wdata", bus_req_wdata, 32'hABCD_ABCD);
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1;
      tick();
      bus_resp_valid = 1'b0;
      #1;
      chk("sh_cmt",   commit, 32'd1);
      chk("sh_rfwen", rf_wen, 32'd0);
      tick();
      pc = pc + 32'd4; clr_dec();
      #1;
      chk("sh_once", commit, 32'd0);

      // Case A: misaligned lw traps, no further requests
      fetch(32'h0010_2083);
      dec_mem_ren = 1'b1; dec_reg_wen = 1'b1; dec_mem_op = 3'b010; lsu_addr = 32'h8000_0401;
      #1;
      chk("mis_cmt", commit, 32'd0);
      tick();
      clr_dec();
      bus_req_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("err_halt",  halt, 32'd1);
         chk("err_vld",   bus_req_valid, 32'd0);
         chk("err_rrdy",  bus_resp_ready, 32'd0);
         chk("err_pcwen", pc_wen, 32'd0);
         tick();
      end
      bus_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstA_halt", halt, 32'd0);
      tick();
      rst_n = 1'b1; pc = 32'h8000_0000;

      // Case B: error response on fetch
      bus_req_ready = 1'b1;
      #1;
      chk("B_vld", bus_req_valid, 32'd1);
      tick();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_resp_rdata = 32'h0050_0093;
      tick();
      bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
      #1;
      chk("B_halt", halt, 32'd1);
      chk("B_inst", inst, 32'h0000_0013);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;

      // Case C: reset while a load waits for its response
      fetch(32'h0000_2083);
      dec_mem_ren = 1'b1; dec_reg_wen = 1'b1; dec_mem_op = 3'b010; lsu_addr = 32'h8000_0010;
      tick();
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      #1;
      chk("C_rrdy", bus_resp_ready, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("C_rst_vld",  bus_req_valid, 32'd0);
      chk("C_rst_rrdy", bus_resp_ready, 32'd0);
      chk("C_rst_halt", halt, 32'd0);
      tick();
      rst_n = 1'b1; pc = 32'h8000_0000; clr_dec();
      bus_resp_valid = 1'b1; bus_resp_rdata = 32'hFFFF_FFFF;
      #1;
      chk("C_vld",  bus_req_valid, 32'd1);
      chk("C_addr", bus_req_addr, 32'h8000_0000);
      chk("C_rrdy0", bus_resp_ready, 32'd0);
      tick();
      bus_resp_valid = 1'b0;
      #1;
      chk("C_inst",  inst, 32'h0000_0013);
      chk("C_ldata", load_data, 32'h0);
      chk("C_vld2",  bus_req_valid, 32'd1);
      fetch(32'h0010_0093);
      dec_reg_wen = 1'b1;
      #1;
      chk("C_cmt",  commit, 32'd1);
      chk("C_inst2", inst, 32'h0010_0093);
      tick();
      clr_dec();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_25030081_exec_seq.md
Name: ysyx_25030081_exec_seq

Overview:
- Multi-cycle sequencer for the RV32I core.
- Sequences fetch, execute, memory access and writeback around the combinational decoder, ALU and register file.
- Owns the core's single shared memory bus port, used for both instruction fetch and load/store.
- Generates the PC/register-file write enables and aligns and extends load data.

Parameters:
- RESET_PC, 32'h8000_0000: documentation only; the PC register resets to it, and the first fetch uses it.
- ADDR_W, 32: bus address width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  ADDR_W  current PC from the PC register.
- inst  out  32  instruction register; feeds the decoder.
- dec_reg_wen  in  1  decoder register-write request.
- dec_mem_ren  in  1  decoder load.
- dec_mem_wen  in  1  decoder store.
- dec_mem_op  in  3  size/sign: [2]=unsigned, [1]=word, [0]=half; 000 = byte.
- lsu_addr  in  ADDR_W  ALU effective address.
- lsu_wdata  in  32  rs2 store data.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_req_addr  out  ADDR_W  byte address; word-aligned (low 2 bits 0).
- bus_req_wen  out  1  1 = write.
- bus_req_wdata  out  32  lane-shifted store data.
- bus_req_wmask  out  4  byte-lane strobes.
- bus_resp_valid  in  1  response valid.
- bus_resp_ready  out  1  response accepted.
- bus_resp_rdata  in  32  read data.
- bus_resp_err  in  1  bus error, qualified by bus_resp_valid.
- pc_wen  out  1  PC update strobe.
- rf_wen  out  1  register-file write strobe.
- load_data  out  32  aligned, extended load result.
- commit  out  1  one-cycle pulse per retired instruction.
- halt  out  1  sticky error indication.

Behaviour:
- Clock and reset: clk is the single clock; rst_n is asynchronous, active-low.
- Reset values:
  - state = IF_REQ.
  - inst = 32'h0000_0013 (NOP).
  - load_data = 0.
  - halt = 0.
  - All strobes and bus valid/ready = 0 while rst_n is low.
- States: IF_REQ, IF_WAIT, EX, MEM_REQ, MEM_WAIT, WB, ERR.
- IF_REQ:
  - bus_req_valid=1, addr={pc[31:2],2'b00}, wen=0, wmask=0.
  - On bus_req_ready: go to IF_WAIT.
- IF_WAIT:
  - bus_resp_ready=1.
  - On resp_valid & !err: inst <= rdata, go to EX.
  - On resp_valid & err: go to ERR.
- EX (exactly one cycle; decoder outputs valid):
  - If dec_mem_ren|dec_mem_wen and access is misaligned: go to ERR. Misaligned = half with lsu_addr[0]=1, or word with lsu_addr[1:0]!=0.
  - Else if dec_mem_ren|dec_mem_wen: go to MEM_REQ.
  - Else: pc_wen=1, rf_wen=dec_reg_wen, commit=1, go to IF_REQ.
- MEM_REQ:
  - bus_req_valid=1, addr={lsu_addr[31:2],2'b00}, wen=dec_mem_wen.
  - Store: wdata = lsu_wdata replicated to the lane (byte ×4, half ×2).
  - Store wmask, with off = lsu_addr[1:0]: byte 4'b0001<<off; half 4'b0011<<off; word 4'hF.
  - Load: wmask = 0.
  - On ready: go to MEM_WAIT.
- MEM_WAIT:
  - bus_resp_ready=1.
  - On resp_valid & err: go to ERR.
  - On resp_valid & !err: if load, load_data <= selected lane, zero-extended if dec_mem_op[2] else sign-extended. Go to WB.
- WB:
  - pc_wen=1, rf_wen=dec_reg_wen, commit=1, go to IF_REQ.
  - A store with dec_reg_wen=0 gives rf_wen=0.
- ERR:
  - halt=1; all strobes and bus valid/ready = 0.
  - Only reset exits ERR.
- Request stability:
  - Request fields are combinational from pc/inst-derived inputs.
  - They stay stable while valid is high, because pc and inst change only at commit and fetch.
  - bus_req_valid never drops before ready.
- bus_resp_valid outside IF_WAIT/MEM_WAIT is ignored.
- At most one outstanding transaction.
- Response timing: a response may arrive the cycle after the accept, or later. A response in the same cycle as the accept is not sampled.
- Latency:
  - Non-memory instruction: 3 cycles (IF_REQ, IF_WAIT, EX) with zero-wait bus.
  - Load/store: 6 cycles with zero-wait bus.
- pc_wen and rf_wen are asserted only in the commit cycle, never together with bus_req_valid.
- Reset mid-transaction returns to IF_REQ immediately; the in-flight response is dropped, and the bus is reset by the same rst_n.

Test Plan:
- Reset release, zero-wait bus, fetch of addi (32'h00100093) at 32'h8000_0000:
  - req addr 32'h8000_0000.
  - commit, pc_wen and rf_wen high in cycle 3.
  - inst=32'h00100093.
- lb at lsu_addr 32'h8000_0103, rdata 32'h80AB_CDEF:
  - req addr 32'h8000_0100, wmask 0.
  - load_data=32'hFFFF_FF80.
  - rf_wen in WB.
- lhu at 32'h...02, rdata 32'h8765_4321 -> load_data=32'h0000_8765.
- sh at 32'h...02, rs2 32'h1234_ABCD -> wmask 4'b1100, wdata 32'hABCD_ABCD, rf_wen=0, commit once.
- Bus stalls:
  - req_ready held low 5 cycles -> valid and addr unchanged throughout.
  - resp delayed 3 cycles -> no commit until the response arrives.
- Error and reset:
  - Case A: lw at 32'h...01 -> ERR, halt=1, no further bus requests.
  - Case B: resp_err on fetch -> ERR.
  - Case C: rst_n pulsed in MEM_WAIT -> IF_REQ, halt=0, stale response ignored.
